// File: rtl/regfile_scan_checker_pkg.sv
// ============================================================================
// regfile_scan_checker_pkg : shared types and sizes for the regfile scan harness
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_scan_checker_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int ERR_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_SCAN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/regfile_scan_checker_if.sv
// ============================================================================
// regfile_scan_checker_if : processor / regfile / ROM / status bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface regfile_scan_checker_if #(
  parameter int CYCLE_W = 10,
  parameter int DATA_W  = 32
);
  import regfile_scan_checker_pkg::*;

  logic                 start;
  logic [CYCLE_W-1:0]   num_cycles;
  logic [REG_IDX_W-1:0] proc_rs1;
  logic [DATA_W-1:0]    regA;
  logic [REG_IDX_W-1:0] rs1_out;
  logic [REG_IDX_W-1:0] exp_addr;
  logic [DATA_W-1:0]    exp_data;
  logic                 proc_stall;
  logic                 test_mode;
  logic [CYCLE_W-1:0]   cycles_run;
  logic                 mismatch_valid;
  logic [REG_IDX_W-1:0] mismatch_reg;
  logic [DATA_W-1:0]    mismatch_exp;
  logic [DATA_W-1:0]    mismatch_act;
  logic [ERR_W-1:0]     err_count;
  logic                 done;
  logic                 pass;

  modport master (
    output start, num_cycles, proc_rs1, regA, exp_data,
    input  rs1_out, exp_addr, proc_stall, test_mode, cycles_run,
           mismatch_valid, mismatch_reg, mismatch_exp, mismatch_act,
           err_count, done, pass
  );

  modport slave (
    input  start, num_cycles, proc_rs1, regA, exp_data,
    output rs1_out, exp_addr, proc_stall, test_mode, cycles_run,
           mismatch_valid, mismatch_reg, mismatch_exp, mismatch_act,
           err_count, done, pass
  );

endinterface

`default_nettype wire

// File: rtl/regfile_scan_checker_scan_compare.sv
// ============================================================================
// regfile_scan_checker_scan_compare : aligns regA with the ROM word and counts
// mismatches.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scan_checker_scan_compare
  import regfile_scan_checker_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_i,
  input  logic                 issue_valid_i,
  input  logic [REG_IDX_W-1:0] issue_idx_i,
  input  logic [DATA_W-1:0]    regA_i,
  input  logic [DATA_W-1:0]    exp_data_i,
  output logic                 mismatch_valid_o,
  output logic [REG_IDX_W-1:0] mismatch_reg_o,
  output logic [DATA_W-1:0]    mismatch_exp_o,
  output logic [DATA_W-1:0]    mismatch_act_o,
  output logic [ERR_W-1:0]     err_count_o
);

  logic                 tag_valid_q;
  logic [REG_IDX_W-1:0] tag_idx_q;
  logic [DATA_W-1:0]    tag_act_q;
  logic                 mis_d;

  // The ROM answers one cycle after its address, so regA is held for a cycle to meet it.
  assign mis_d = tag_valid_q && (exp_data_i != tag_act_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tag_valid_q      <= 1'b0;
      tag_idx_q        <= '0;
      tag_act_q        <= '0;
      mismatch_valid_o <= 1'b0;
      mismatch_reg_o   <= '0;
      mismatch_exp_o   <= '0;
      mismatch_act_o   <= '0;
      err_count_o      <= '0;
    end else begin
      tag_valid_q      <= issue_valid_i;
      tag_idx_q        <= issue_idx_i;
      tag_act_q        <= regA_i;
      mismatch_valid_o <= mis_d;
      if (mis_d) begin
        mismatch_reg_o <= tag_idx_q;
        mismatch_exp_o <= exp_data_i;
        mismatch_act_o <= tag_act_q;
      end
      if (clear_i) begin
        err_count_o <= '0;
      end else if (mis_d) begin
        err_count_o <= err_count_o + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_scan_checker.sv
// ============================================================================
// regfile_scan_checker : runs the processor N cycles, freezes it, then scans the
// register file through read port A against an expected-value ROM.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_scan_checker
  import regfile_scan_checker_pkg::*;
#(
  parameter int CYCLE_W = 10,
  parameter int DATA_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  regfile_scan_checker_if.slave bus
);

  localparam logic [REG_IDX_W-1:0] LAST_IDX = REG_IDX_W'(NUM_REGS - 1);

  state_e               state_q, state_d;
  logic [CYCLE_W-1:0]   num_q;
  logic [CYCLE_W-1:0]   cycles_q;
  logic [REG_IDX_W-1:0] idx_q;
  logic                 start_ok;
  logic                 issue_valid;
  logic                 test_mode;
  logic [ERR_W-1:0]     err_count;

  assign start_ok = bus.start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    issue_valid = 1'b0;
    test_mode   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = (bus.num_cycles == '0) ? ST_SCAN : ST_RUN;
      end
      ST_RUN: begin
        if (cycles_q == num_q - 1'b1) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        issue_valid = 1'b1;
        test_mode   = 1'b1;
        if (idx_q == LAST_IDX) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        test_mode = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        test_mode = 1'b1;
        if (start_ok) state_d = (bus.num_cycles == '0) ? ST_SCAN : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_q    <= '0;
      cycles_q <= '0;
      idx_q    <= '0;
    end else begin
      if (start_ok) begin
        num_q    <= bus.num_cycles;
        cycles_q <= '0;
      end else if (state_q == ST_RUN) begin
        cycles_q <= cycles_q + 1'b1;
      end
      // Held at zero outside SCAN so every scan starts from register 0.
      idx_q <= issue_valid ? idx_q + 1'b1 : '0;
    end
  end

  assign bus.proc_stall = (state_q != ST_RUN);
  assign bus.test_mode  = test_mode;
  assign bus.rs1_out    = test_mode ? (issue_valid ? idx_q : '0) : bus.proc_rs1;
  assign bus.exp_addr   = issue_valid ? idx_q : '0;
  assign bus.cycles_run = cycles_q;
  assign bus.err_count  = err_count;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_count == '0);

  regfile_scan_checker_scan_compare #(
    .DATA_W (DATA_W)
  ) u_scan_compare (
    .clock            (clock),
    .reset            (reset),
    .clear_i          (start_ok),
    .issue_valid_i    (issue_valid),
    .issue_idx_i      (idx_q),
    .regA_i           (bus.regA),
    .exp_data_i       (bus.exp_data),
    .mismatch_valid_o (bus.mismatch_valid),
    .mismatch_reg_o   (bus.mismatch_reg),
    .mismatch_exp_o   (bus.mismatch_exp),
    .mismatch_act_o   (bus.mismatch_act),
    .err_count_o      (err_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_scan_checker.sv
// ============================================================================
// tb_regfile_scan_checker : directed bench with a regfile model and a
// synchronous expected-value ROM model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scan_checker;
  import regfile_scan_checker_pkg::*;

  localparam int CW = 10;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  regfile_scan_checker_if #(.CYCLE_W(CW), .DATA_W(DW)) bus ();

  regfile_scan_checker #(.CYCLE_W(CW), .DATA_W(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  logic [DW-1:0] rf  [NUM_REGS];
  logic [DW-1:0] rom [NUM_REGS];

  assign bus.regA = rf[bus.rs1_out];
  always @(posedge clock) bus.exp_data <= rom[bus.exp_addr];

  int             stall_low_cnt = 0;
  int             scan_cnt      = 0;
  logic [4:0]     p_reg [$];
  logic [DW-1:0]  p_exp [$];
  logic [DW-1:0]  p_act [$];

  always @(negedge clock) begin
    if (!reset) begin
      if (!bus.proc_stall) stall_low_cnt++;
      if (bus.test_mode && !bus.done) scan_cnt++;
      if (bus.mismatch_valid) begin
        p_reg.push_back(bus.mismatch_reg);
        p_exp.push_back(bus.mismatch_exp);
        p_act.push_back(bus.mismatch_act);
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_run(input int n);
    bus.num_cycles = CW'(n);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Waits for done, then one more cycle so the monitor has seen the last pulse.
  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!bus.done && k < 400) begin
      tick();
      k++;
    end
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    tick();
  endtask

  initial begin
    int  s0, c0, q0, k;
    bit  ordered;

    bus.start      = 1'b0;
    bus.num_cycles = '0;
    bus.proc_rs1   = 5'd9;
    for (int i = 0; i < NUM_REGS; i++) begin
      rf[i]  = 32'hA500_0000 + 32'(i) * 32'h0000_0111;
      rom[i] = rf[i];
    end

    tick();
    tick();
    check("rst_stall",    64'(bus.proc_stall),     64'd1);
    check("rst_tmode",    64'(bus.test_mode),      64'd0);
    check("rst_done",     64'(bus.done),           64'd0);
    check("rst_pass",     64'(bus.pass),           64'd0);
    check("rst_err",      64'(bus.err_count),      64'd0);
    check("rst_cycles",   64'(bus.cycles_run),     64'd0);
    check("rst_mvalid",   64'(bus.mismatch_valid), 64'd0);
    check("rst_expaddr",  64'(bus.exp_addr),       64'd0);
    check("rst_rs1",      64'(bus.rs1_out),        64'd9);
    reset = 1'b0;
    tick();

    // All registers match, 5-cycle run, with a stray start during RUN.
    s0 = stall_low_cnt; c0 = scan_cnt; q0 = p_reg.size();
    start_run(5);
    check("t1_run_stall", 64'(bus.proc_stall), 64'd0);
    check("t1_run_tmode", 64'(bus.test_mode),  64'd0);
    bus.proc_rs1 = 5'd13;
    #1;
    check("t1_run_rs1",   64'(bus.rs1_out),    64'd13);
    tick();
    bus.num_cycles = 10'd20;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.num_cycles = 10'd5;
    wait_done("t1");
    check("t1_stall_low", 64'(stall_low_cnt - s0), 64'd5);
    check("t1_scan_len",  64'(scan_cnt - c0),      64'd33);
    check("t1_cycles",    64'(bus.cycles_run),     64'd5);
    check("t1_err",       64'(bus.err_count),      64'd0);
    check("t1_pass",      64'(bus.pass),           64'd1);
    check("t1_pulses",    64'(p_reg.size() - q0),  64'd0);
    check("t1_rs1_done",  64'(bus.rs1_out),        64'd0);
    check("t1_tmode",     64'(bus.test_mode),      64'd1);
    check("t1_stall",     64'(bus.proc_stall),     64'd1);

    // Register 7 holds 42, ROM expects 41.
    rf[7]  = 32'd42;
    rom[7] = 32'd41;
    q0 = p_reg.size();
    start_run(4);
    check("t2_done_clr",  64'(bus.done),           64'd0);
    wait_done("t2");
    check("t2_pulses",    64'(p_reg.size() - q0),  64'd1);
    check("t2_reg",       64'(p_reg[q0]),          64'd7);
    check("t2_exp",       64'(p_exp[q0]),          64'd41);
    check("t2_act",       64'(p_act[q0]),          64'd42);
    check("t2_err",       64'(bus.err_count),      64'd1);
    check("t2_pass",      64'(bus.pass),           64'd0);
    check("t2_cycles",    64'(bus.cycles_run),     64'd4);
    check("t2_hold_reg",  64'(bus.mismatch_reg),   64'd7);

    // Every register off by one.
    for (int i = 0; i < NUM_REGS; i++) rom[i] = rf[i] + 32'd1;
    q0 = p_reg.size();
    start_run(2);
    wait_done("t3");
    check("t3_pulses",    64'(p_reg.size() - q0),  64'd32);
    ordered = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (p_reg[q0 + i] !== 5'(i)) ordered = 1'b0;
    end
    check("t3_order",     64'(ordered),            64'd1);
    check("t3_err",       64'(bus.err_count),      64'd32);
    check("t3_pass",      64'(bus.pass),           64'd0);
    check("t3_last_exp",  64'(bus.mismatch_exp),   64'(rf[31] + 32'd1));
    check("t3_last_act",  64'(bus.mismatch_act),   64'(rf[31]));

    // Zero-length run restarted from DONE.
    for (int i = 0; i < NUM_REGS; i++) rom[i] = rf[i];
    s0 = stall_low_cnt;
    start_run(0);
    check("t4_done_clr",  64'(bus.done),           64'd0);
    check("t4_err_clr",   64'(bus.err_count),      64'd0);
    check("t4_tmode",     64'(bus.test_mode),      64'd1);
    check("t4_stall",     64'(bus.proc_stall),     64'd1);
    check("t4_addr0",     64'(bus.exp_addr),       64'd0);
    tick();
    check("t4_addr1",     64'(bus.exp_addr),       64'd1);
    check("t4_rs1_1",     64'(bus.rs1_out),        64'd1);
    wait_done("t4");
    check("t4_cycles",    64'(bus.cycles_run),     64'd0);
    check("t4_stall_low", 64'(stall_low_cnt - s0), 64'd0);
    check("t4_pass",      64'(bus.pass),           64'd1);

    // Reset in the middle of a scan after two mismatches.
    rom[2] = rf[2] ^ 32'd1;
    rom[5] = rf[5] ^ 32'd1;
    start_run(1);
    k = 0;
    while (!(bus.test_mode && bus.exp_addr == 5'd10) && k < 100) begin
      tick();
      k++;
    end
    check("t5_reach10",   64'(bus.exp_addr),       64'd10);
    check("t5_err_pre",   64'(bus.err_count),      64'd2);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_stall", 64'(bus.proc_stall),     64'd1);
    check("t5_rst_tmode", 64'(bus.test_mode),      64'd0);
    check("t5_rst_err",   64'(bus.err_count),      64'd0);
    check("t5_rst_done",  64'(bus.done),           64'd0);
    check("t5_rst_rs1",   64'(bus.rs1_out),        64'd13);
    tick();
    reset = 1'b0;
    rom[2] = rf[2];
    rom[5] = rf[5];
    tick();
    start_run(3);
    wait_done("t5");
    check("t5_cycles",    64'(bus.cycles_run),     64'd3);
    check("t5_err",       64'(bus.err_count),      64'd0);
    check("t5_pass",      64'(bus.pass),           64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_scan_checker.md
Name: regfile_scan_checker

Overview:
- Synthesizable self-check harness for the processor's register file.
- Runs the processor for a programmed number of cycles, then freezes it and takes over regfile read port A.
- Walks all 32 registers and compares each against an expected-value ROM, reporting per-register mismatches, an error count and a final pass flag.
- Sits between the processor and the regfile on ctrl_readRegA, and drives the processor's stall input.

Parameters:
- NUM_REGS, 32, registers scanned, indices 0..NUM_REGS-1.
- CYCLE_W, 10, width of the run-cycle counter and num_cycles.
- DATA_W, 32, register and expected-data width.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- num_cycles  in  CYCLE_W  run length, latched on accepted start.
- proc_rs1  in  5  processor's ctrl_readRegA.
- regA  in  DATA_W  regfile data_readRegA, combinational from rs1_out.
- rs1_out  out  5  to regfile ctrl_readRegA.
- exp_addr  out  5  expected-ROM address.
- exp_data  in  DATA_W  expected-ROM data, synchronous read (valid the cycle after exp_addr).
- proc_stall  out  1  processor clock-enable hold; 1 = frozen.
- test_mode  out  1  high while the harness owns read port A.
- cycles_run  out  CYCLE_W  cycles executed in RUN.
- mismatch_valid  out  1  one-cycle pulse per failing register.
- mismatch_reg  out  5  failing register index.
- mismatch_exp, mismatch_act  out  DATA_W  expected and actual values.
- err_count  out  6  total mismatches, 0..32.
- done  out  1  scan complete, held.
- pass  out  1  done && err_count==0.

Behaviour:
- Reset values:
  - State IDLE.
  - proc_stall=1; all other outputs 0.
  - rs1_out=proc_rs1 (test_mode=0).
- States: IDLE, RUN, SCAN, DRAIN, DONE.
- IDLE:
  - proc_stall=1.
  - On start: latch num_cycles, clear cycles_run, err_count, done and pass.
  - Go to RUN, or directly to SCAN if num_cycles==0.
- RUN:
  - proc_stall=0; cycles_run increments every cycle.
  - When cycles_run reaches latched num_cycles-1, the next state is SCAN.
  - A run of N cycles therefore spans exactly N RUN cycles; cycles_run ends at N.
- SCAN:
  - proc_stall=1, test_mode=1.
  - Scan index i starts at 0 on entry; rs1_out=exp_addr=i; i increments each cycle.
  - Each issue is tagged with a valid bit and its index for the next cycle.
  - On the issue of i=NUM_REGS-1, the next state is DRAIN.
- Compare stage (SCAN and DRAIN):
  - regA is registered alongside the issued index so it aligns with exp_data one cycle later.
  - A valid tag with exp_data != captured regA gives: mismatch_valid=1, mismatch_reg/exp/act loaded, err_count+1.
  - Register 0 is compared like any other register.
- DRAIN: one cycle completing the compare of the last register, then DONE.
- Scan length: 32 issue cycles + 1 drain = 33 cycles from SCAN entry to DONE.
- DONE:
  - done=1; pass=(err_count==0).
  - proc_stall=1, test_mode=1; rs1_out holds 0.
  - Outputs hold until start (restart from the IDLE-start actions) or reset.
- start during RUN/SCAN/DRAIN: ignored.
- test_mode=0 in IDLE and RUN: rs1_out=proc_rs1 combinationally.
- exp_addr=0 outside SCAN.
- err_count max is 32 (fits 6 bits); no saturation logic.
- Reset mid-RUN or mid-SCAN: immediate asynchronous return to IDLE with reset values; any partial err_count is discarded.
- mismatch_* data fields hold their last value between pulses.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN, SCAN, DRAIN, DONE}
  - NUM_REGS=32
  - REG_IDX_W=5
  - ERR_W=6
- One sub-module, scan_compare: registers the (valid, idx, regA) tag, compares it against exp_data, and produces the mismatch pulse/fields and the err_count increment.
- The top holds the FSM, the run counter and the rs1 mux.

Test Plan:
- All registers match (expected ROM = regfile contents, num_cycles=5):
  - proc_stall low for exactly 5 cycles; cycles_run=5.
  - done asserted 33 cycles after SCAN entry; err_count=0; pass=1; no mismatch_valid pulses.
- Register 7 holds 42 but the ROM expects 41:
  - One mismatch_valid pulse with mismatch_reg=7, exp=41, act=42.
  - err_count=1; pass=0.
- Every register off by one: 32 consecutive pulses, regs 0..31 in order; err_count=32.
- num_cycles=0: SCAN entered on the cycle after start; proc_stall never deasserts; cycles_run=0.
- Reset asserted at SCAN index 10 after 2 mismatches:
  - Immediately IDLE, err_count=0, done=0.
  - A following start with num_cycles=3 runs clean to pass=1.
- Mux and handshake rules:
  - start pulsed during RUN: no effect on the latched count.
  - test_mode=0 in RUN: rs1_out tracks proc_rs1 (e.g. 13) the same cycle.
  - start in DONE: err_count and done cleared, new run begins.
